// File: rtl/commit_buffer.sv
// commit_buffer: in-order retirement buffer in front of the register file.
// Issue allocates entries in program order, tagged results arrive out of
// order on the CDB, and at most one completed head entry retires per cycle
// through the registered write port.
// Optional build macro: COMMIT_BYPASS_EN -- lets a CDB result aimed at the
// waiting head retire in the same cycle it is broadcast (1-cycle latency).
module commit_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             write_or_not,
    output logic [4:0]       writeaddr,
    output logic [31:0]      writedata,
    output logic             empty_out
);

    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic             do_alloc;
    logic             do_complete;
    logic             do_retire;
    logic [4:0]       retire_rd;
    logic [31:0]      retire_data;

    // Full is judged on the pre-retire count, so a full buffer refuses
    // allocation even in a cycle where its head retires.
    assign alloc_ready = (count_q != CNT_W'(DEPTH)) && !flush_in;
    assign alloc_tag   = tail_q;
    assign empty_out   = (count_q == '0);
    assign do_alloc    = alloc_valid && alloc_ready;
    // The tail entry is never valid when allocation is possible, so a result
    // tagged with the tail in the allocating cycle is dropped here.
    assign do_complete = cdb_valid && valid_q[cdb_tag];

    // Retire decision for the head entry and the value it will write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        do_retire   = 1'b0;
        retire_rd   = rd_mem[head_q];
        retire_data = data_mem[head_q];
        if (valid_q[head_q] && done_q[head_q]) begin
            do_retire = 1'b1;
        end
`ifdef COMMIT_BYPASS_EN
        else if (valid_q[head_q] && cdb_valid && (cdb_tag == head_q)) begin
            do_retire   = 1'b1;
            retire_data = cdb_data;
        end
`endif
    end

    // Entry status, pointers and occupancy; flush and reset both empty the buffer.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: non-blocking updates; when completion and retire touch the
            // same entry, the later retire clear is the one that sticks.
            if (do_complete) begin
                done_q[cdb_tag] <= 1'b1;
            end
            if (do_retire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            case ({do_alloc, do_retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload storage, qualified by the valid bits above.
    always_ff @(posedge clk_in) begin
        // NOTE: the payload arrays carry no reset; an entry is only read once
        // its valid bit (which is reset) says it was written.
        if (do_alloc) begin
            rd_mem[tail_q] <= alloc_rd;
        end
        if (do_complete) begin
            data_mem[cdb_tag] <= cdb_data;
        end
    end

    // Registered register-file write port; address and data hold when idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            write_or_not <= 1'b0;
            writeaddr    <= '0;
            writedata    <= '0;
        end else if (flush_in) begin
            write_or_not <= 1'b0;
        end else if (do_retire) begin
            write_or_not <= (retire_rd != 5'd0);
            writeaddr    <= retire_rd;
            writedata    <= retire_data;
        end else begin
            write_or_not <= 1'b0;
        end
    end

endmodule

// File: tb/tb_commit_buffer.sv
// Self-checking bench for commit_buffer: directed scenarios from the test
// plan plus a randomized run against a queue-based program-order model.
module tb_commit_buffer;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             flush_in;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             write_or_not;
    logic [4:0]       writeaddr;
    logic [31:0]      writedata;
    logic             empty_out;

    int total = 0;
    int bad   = 0;

`ifdef COMMIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    commit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_in     (flush_in),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .write_or_not (write_or_not),
        .writeaddr    (writeaddr),
        .writedata    (writedata),
        .empty_out    (empty_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: in-flight instructions in program order; element 0 is
    // the oldest and carries tag m_head, element i carries (m_head+i)%DEPTH.
    typedef struct {
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t        rob[$];
    int          m_head = 0;
    bit          m_we   = 1'b0;
    logic [4:0]  m_wa   = '0;
    logic [31:0] m_wd   = '0;

    function automatic bit m_ready();
        return (rob.size() != DEPTH) && !flush_in;
    endfunction

    function automatic int m_tail();
        return (m_head + rob.size()) % DEPTH;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit          ready;
        bit          ret;
        logic [4:0]  r_rd;
        logic [31:0] r_data;
        int          idx;
        ready  = (rob.size() != DEPTH);
        ret    = 1'b0;
        r_rd   = '0;
        r_data = '0;
        if (rst_in) begin
            rob.delete();
            m_head = 0;
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
        end else if (flush_in) begin
            rob.delete();
            m_head = 0;
            m_we   = 1'b0;
        end else begin
            if (rob.size() > 0 && rob[0].done) begin
                ret    = 1'b1;
                r_rd   = rob[0].rd;
                r_data = rob[0].data;
            end else if (BYPASS && rob.size() > 0 && cdb_valid && int'(cdb_tag) == m_head) begin
                ret    = 1'b1;
                r_rd   = rob[0].rd;
                r_data = cdb_data;
            end
            if (cdb_valid) begin
                idx = (int'(cdb_tag) - m_head + DEPTH) % DEPTH;
                if (idx < rob.size()) begin
                    rob[idx].done = 1'b1;
                    rob[idx].data = cdb_data;
                end
            end
            if (ret) begin
                m_we = (r_rd != 5'd0);
                m_wa = r_rd;
                m_wd = r_data;
                void'(rob.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end else begin
                m_we = 1'b0;
            end
            if (alloc_valid && ready) begin
                rob.push_back('{alloc_rd, 1'b0, 32'h0});
            end
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] rd, input bit cv,
                         input logic [TAG_W-1:0] tag, input logic [31:0] d,
                         input bit fl);
        alloc_valid = av;
        alloc_rd    = rd;
        cdb_valid   = cv;
        cdb_tag     = tag;
        cdb_data    = d;
        flush_in    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    // One clock edge; returns 1 time unit after the edge with outputs settled.
    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b want=1", alloc_ready); end
        total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL reset_alloc_tag got=%0d want=0", alloc_tag); end
        total++; if (empty_out !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty_out); end
        total++; if (write_or_not !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", write_or_not); end
        total++; if (writeaddr !== 5'd0 || writedata !== 32'd0) begin bad++; $display("FAIL reset_wport got=%0d/%h want=0/0", writeaddr, writedata); end
        // Reset while a result is arriving for the head: nothing is written.
        drive(1'b1, 5'd3, 1'b0, '0, 32'h0, 1'b0);
        tick();
        rst_in = 1'b1;
        drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hAA, 1'b0);
        tick();
        rst_in = 1'b0;
        idle();
        total++; if (write_or_not !== 1'b0) begin bad++; $display("FAIL midreset_we got=%0b want=0", write_or_not); end
        tick();
        total++; if (write_or_not !== 1'b0 || empty_out !== 1'b1) begin bad++; $display("FAIL midreset_after got=we%0b/empty%0b want=we0/empty1", write_or_not, empty_out); end
    endtask

    task automatic test_out_of_order();
        logic [4:0]  exp_rd [3];
        logic [31:0] exp_wd [3];
        logic [TAG_W-1:0] c_tag [3];
        logic [31:0] c_dat [3];
        logic [4:0]  got_rd [$];
        logic [31:0] got_wd [$];
        int          got_cyc [$];
        exp_rd = '{5'd5, 5'd6, 5'd7};
        exp_wd = '{32'h11, 32'h22, 32'h33};
        c_tag  = '{3'd2, 3'd0, 3'd1};
        c_dat  = '{32'h33, 32'h11, 32'h22};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, exp_rd[i], 1'b0, '0, 32'h0, 1'b0);
            #1;
            total++; if (alloc_tag !== TAG_W'(i)) begin bad++; $display("FAIL ooo_alloc_tag got=%0d want=%0d", alloc_tag, i); end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            if (c < 3) drive(1'b0, 5'd0, 1'b1, c_tag[c], c_dat[c], 1'b0);
            else idle();
            tick();
            if (write_or_not === 1'b1) begin
                got_rd.push_back(writeaddr);
                got_wd.push_back(writedata);
                got_cyc.push_back(c);
            end
        end
        total++; if (got_rd.size() != 3) begin bad++; $display("FAIL ooo_write_count got=%0d want=3", got_rd.size()); end
        for (int i = 0; i < 3 && i < got_rd.size(); i++) begin
            total++; if (got_rd[i] !== exp_rd[i] || got_wd[i] !== exp_wd[i]) begin bad++; $display("FAIL ooo_write%0d got=%0d/%h want=%0d/%h", i, got_rd[i], got_wd[i], exp_rd[i], exp_wd[i]); end
        end
        if (got_cyc.size() == 3) begin
            total++; if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin bad++; $display("FAIL ooo_consecutive got=%0d,%0d,%0d want=consecutive", got_cyc[0], got_cyc[1], got_cyc[2]); end
        end
    endtask

    task automatic test_full();
        bit wrote;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, '0, 32'h0, 1'b0);
            tick();
        end
        idle();
        #1;
        total++; if (alloc_ready !== 1'b0 || empty_out !== 1'b0) begin bad++; $display("FAIL full_ready got=rdy%0b/empty%0b want=rdy0/empty0", alloc_ready, empty_out); end
        drive(1'b1, 5'd9, 1'b0, '0, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        total++; if (alloc_tag !== 3'd0 || alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ignored got=tag%0d/rdy%0b want=tag0/rdy0", alloc_tag, alloc_ready); end
        drive(1'b0, 5'd0, 1'b1, 3'd0, 32'h100, 1'b0);
        tick();
        idle();
        wrote = write_or_not;
        total++; if (alloc_ready !== m_ready()) begin bad++; $display("FAIL full_ready_after_cdb got=%0b want=%0b", alloc_ready, m_ready()); end
        tick();
        wrote = wrote | write_or_not;
        total++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin bad++; $display("FAIL full_ready_after_retire got=rdy%0b/tag%0d want=rdy1/tag0", alloc_ready, alloc_tag); end
        total++; if (!wrote || writeaddr !== 5'd1 || writedata !== 32'h100) begin bad++; $display("FAIL full_retire_write got=%0b/%0d/%h want=1/1/100", wrote, writeaddr, writedata); end
    endtask

    task automatic test_rd_zero();
        bit wrote;
        wrote = 1'b0;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, '0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hDEAD, 1'b0);
        tick();
        wrote = wrote | write_or_not;
        idle();
        tick();
        wrote = wrote | write_or_not;
        tick();
        wrote = wrote | write_or_not;
        total++; if (wrote !== 1'b0) begin bad++; $display("FAIL rd0_no_write got=%0b want=0", wrote); end
        total++; if (empty_out !== 1'b1 || alloc_tag !== 3'd1) begin bad++; $display("FAIL rd0_head_advanced got=empty%0b/tag%0d want=empty1/tag1", empty_out, alloc_tag); end
    endtask

    task automatic test_flush();
        bit wrote;
        wrote = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, '0, 32'h0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 1'b1, 3'd1, 32'h77, 1'b0);
        tick();
        drive(1'b1, 5'd4, 1'b0, '0, 32'h0, 1'b1);
        #1;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks_alloc got=%0b want=0", alloc_ready); end
        tick();
        wrote = wrote | write_or_not;
        idle();
        total++; if (empty_out !== 1'b1 || alloc_tag !== 3'd0) begin bad++; $display("FAIL flush_empty got=empty%0b/tag%0d want=empty1/tag0", empty_out, alloc_tag); end
        drive(1'b0, 5'd0, 1'b1, 3'd1, 32'h55, 1'b0);
        tick();
        wrote = wrote | write_or_not;
        idle();
        tick();
        wrote = wrote | write_or_not;
        tick();
        wrote = wrote | write_or_not;
        total++; if (wrote !== 1'b0 || empty_out !== 1'b1) begin bad++; $display("FAIL flush_stale_ignored got=we%0b/empty%0b want=we0/empty1", wrote, empty_out); end
    endtask

    task automatic test_bypass_timing();
        do_reset();
        drive(1'b1, 5'd9, 1'b0, '0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 1'b1, 3'd0, 32'h1234, 1'b0);
        tick();
        idle();
        total++; if (write_or_not !== BYPASS) begin bad++; $display("FAIL bypass_edge1 got=%0b want=%0b", write_or_not, BYPASS); end
        tick();
        total++; if (write_or_not !== !BYPASS) begin bad++; $display("FAIL bypass_edge2 got=%0b want=%0b", write_or_not, !BYPASS); end
        total++; if (writeaddr !== 5'd9 || writedata !== 32'h1234) begin bad++; $display("FAIL bypass_wport got=%0d/%h want=9/1234", writeaddr, writedata); end
    endtask

    task automatic test_random();
        bit               av;
        bit               cv;
        bit               fl;
        logic [TAG_W-1:0] tag;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            av = ($urandom_range(0, 9) < 6);
            cv = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 99) < 2);
            if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                tag = TAG_W'((m_head + $urandom_range(0, rob.size() - 1)) % DEPTH);
            else
                tag = TAG_W'($urandom_range(0, DEPTH - 1));
            rst_in = ($urandom_range(0, 299) == 0);
            drive(av, 5'($urandom_range(0, 31)), cv, tag, $urandom, fl);
            #1;
            total++; if (alloc_ready !== m_ready() || alloc_tag !== TAG_W'(m_tail()) || empty_out !== (rob.size() == 0)) begin
                bad++; $display("FAIL rand_comb c=%0d got=rdy%0b/tag%0d/empty%0b want=rdy%0b/tag%0d/empty%0b", c, alloc_ready, alloc_tag, empty_out, m_ready(), m_tail(), rob.size() == 0);
            end
            tick();
            total++; if (write_or_not !== m_we || writeaddr !== m_wa || writedata !== m_wd) begin
                bad++; $display("FAIL rand_wport c=%0d got=%0b/%0d/%h want=%0b/%0d/%h", c, write_or_not, writeaddr, writedata, m_we, m_wa, m_wd);
            end
        end
        rst_in = 1'b0;
        idle();
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        test_reset();
        test_out_of_order();
        test_full();
        test_rd_zero();
        test_flush();
        test_bypass_timing();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_buffer.md
Name: commit_buffer

Overview:
- In-order retirement buffer that sits directly upstream of the register file and owns its single write port (write_or_not / writeaddr / writedata).
- Issue allocates one entry per instruction in program order; execution units return results out of order over a CDB-style bus, tagged.
- Each cycle the buffer retires at most one completed head entry to the register file, in program order.
- A flush discards all in-flight entries on branch mispredict.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- TAG_W, 3, entry tag width; equals log2(DEPTH).

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous reset, active-high.
- flush_in  input  1  discard all entries.
- alloc_valid  input  1  issue requests an entry this cycle.
- alloc_rd  input  5  destination register of the allocating instruction.
- alloc_ready  output  1  an entry can be accepted this cycle.
- alloc_tag  output  TAG_W  tag assigned to the allocation; equals the tail pointer.
- cdb_valid  input  1  a result is broadcast this cycle.
- cdb_tag  input  TAG_W  entry the result belongs to.
- cdb_data  input  32  result value.
- write_or_not  output  1  register-file write enable, registered.
- writeaddr  output  5  register-file write address, registered.
- writedata  output  32  register-file write data, registered.
- empty_out  output  1  no entries in flight.

Behaviour:
- State per entry: valid, done, rd[4:0], data[31:0]. Also head pointer, tail pointer, count (0..DEPTH).
- Reset (rst_in=1 at posedge):
  - head=tail=count=0; all valid/done cleared.
  - write_or_not=0, writeaddr=0, writedata=0.
  - Resulting outputs: alloc_ready=1, alloc_tag=0, empty_out=1.
  - Reset mid-operation drops all entries; nothing in flight is ever written.
- alloc_ready = (count != DEPTH) && !flush_in, combinational.
  - Computed from count before any same-cycle retire, so a full buffer refuses allocation even when the head retires that cycle.
- Allocate, when alloc_valid && alloc_ready:
  - entry[tail] gets valid=1, done=0, rd=alloc_rd.
  - tail = tail+1, wrapping modulo DEPTH.
  - alloc_valid while not ready is ignored; issue must hold and retry.
- Complete, when cdb_valid:
  - If entry[cdb_tag].valid, set done=1 and data=cdb_data.
  - A tag that is not valid is ignored (stale result after a flush).
  - A second result for the same tag overwrites data.
- Retire, when entry[head].valid && entry[head].done:
  - Clear valid and done; head = head+1, wrapping.
  - On the next posedge: write_or_not=(rd!=0), writeaddr=rd, writedata=data.
  - Entries with rd=0 retire in order but never assert write_or_not.
  - In any cycle with no retire, write_or_not=0 at the next edge; writeaddr and writedata hold their previous values.
  - Latency: CDB result at edge N, entry done after N, retire decision during cycle N+1, write_or_not high for one cycle after edge N+1. Minimum CDB-to-regfile latency is 2 cycles.
- Count update:
  - count += alloc − retire; simultaneous alloc and retire leaves count unchanged.
  - Allocate and complete in the same cycle: a CDB tag equal to the current tail sees an invalid entry and is ignored.
- Flush (flush_in=1 at posedge), priority flush > retire > alloc/complete:
  - head=tail=count=0; all valid/done cleared; write_or_not=0 next cycle.
  - A write already registered on the flush edge still appears for that one cycle, because it was committed.
- Wrap-around: pointers wrap after DEPTH−1; a full buffer has head==tail with count==DEPTH.
- empty_out = (count==0).

Optional Feature:
- Macro: COMMIT_BYPASS_EN.
- Defined:
  - If the head is valid, not done, and cdb_valid && cdb_tag==head, the head retires in the same cycle using cdb_data directly.
  - Registered write appears one edge after the CDB cycle; minimum latency is 1.
  - All other rules are unchanged.
- Undefined: the 2-cycle minimum latency above applies.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles, release → alloc_ready=1, alloc_tag=0, empty_out=1, write_or_not=0.
- Out-of-order completion:
  - Allocate rd=5, 6, 7 (tags 0, 1, 2).
  - CDB tag2=0x33, tag0=0x11, tag1=0x22.
  - → writes on consecutive cycles in order: (5,0x11), (6,0x22), (7,0x33).
- Full boundary:
  - Allocate 8 entries without completion → alloc_ready=0; a 9th alloc_valid is ignored and tail stays 0.
  - Complete tag0 → one retire; alloc_ready=1 the cycle after.
- rd=0 entry: allocate rd=0, complete 0xDEAD → head advances, write_or_not stays 0, empty_out=1.
- Flush with pending results:
  - Allocate 3 entries, complete tag1, flush_in=1 → empty_out=1, no writes.
  - A stale CDB tag1 afterwards is ignored.
- Bypass timing: allocate rd=9, CDB tag0=0x1234 the next cycle → write_or_not high 1 edge later with COMMIT_BYPASS_EN defined, 2 edges later without it; writeaddr=9, writedata=0x1234.
